// File: rtl/milano_pkg.sv
// Shared M-extension types for the EX-stage multiply/divide path.
// Holds the op encoding, issue-controller states and op-class helpers.
package milano_pkg;

   typedef enum logic [2:0] {
      MD_OP_MUL,
      MD_OP_MULH,
      MD_OP_MULSU,
      MD_OP_MULU,
      MD_OP_DIV,
      MD_OP_DIVU,
      MD_OP_REM,
      MD_OP_REMU
   } md_opt_e;

   typedef enum logic [1:0] {
      MDC_IDLE,
      MDC_MUL,
      MDC_DIV_START,
      MDC_DIV_WAIT
   } md_ctrl_state_e;

   function automatic logic is_div_op(md_opt_e op);
      return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
   endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller in front of the multdiv datapath.
// Latches one M-op, pulses the divider start, stalls, flushes, watchdogs.
module md_issue_ctrl
   import milano_pkg::*;
#(
   parameter int MAX_DIV_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  md_opt_e     req_op_i,
   input  logic [31:0] req_a_i,
   input  logic [31:0] req_b_i,
   input  logic [4:0]  req_rd_addr_i,
   input  logic        req_rd_we_i,
   output md_opt_e     md_operate_o,
   output logic [31:0] md_operand_a_o,
   output logic [31:0] md_operand_b_o,
   output logic [4:0]  md_rd_addr_o,
   output logic        md_rd_we_o,
   output logic        div_start_o,
   input  logic        div_done_i,
   input  logic        div_busy_i,
   input  logic        refresh_pip_i,
   output logic        refresh_pip_o,
   output logic        stall_o,
   output logic        wb_valid_o,
   output logic        timeout_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIV_CYCLES - 1);

   md_ctrl_state_e    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   md_opt_e           op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [4:0]        rd_q, rd_d;
   logic              we_q, we_d;
   logic              wb, ds, to;
   logic              busy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      we_d    = we_q;
      wb      = 1'b0;
      ds      = 1'b0;
      to      = 1'b0;
      unique case (state_q)
         MDC_IDLE: begin
            if (req_valid_i && !refresh_pip_i) begin
               op_d    = req_op_i;
               a_d     = req_a_i;
               b_d     = req_b_i;
               rd_d    = req_rd_addr_i;
               we_d    = req_rd_we_i;
               state_d = is_div_op(req_op_i) ? MDC_DIV_START : MDC_MUL;
            end
         end
         MDC_MUL: begin
            wb      = !refresh_pip_i;
            state_d = MDC_IDLE;
         end
         MDC_DIV_START: begin
            cnt_d = '0;
            if (refresh_pip_i) begin
               state_d = MDC_IDLE;
            end else begin
               ds = 1'b1;
               if (!div_busy_i) state_d = MDC_DIV_WAIT;
            end
         end
         MDC_DIV_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // flush outranks both completion and watchdog expiry
            if (refresh_pip_i) begin
               state_d = MDC_IDLE;
            end else if (div_done_i) begin
               wb      = 1'b1;
               state_d = MDC_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               to      = 1'b1;
               state_d = MDC_IDLE;
            end
         end
         default: state_d = MDC_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= MDC_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_OP_MUL;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
      end
   end

   assign busy           = (state_q != MDC_IDLE);
   assign req_ready_o    = !busy && !refresh_pip_i;
   assign md_operate_o   = op_q;
   assign md_operand_a_o = a_q;
   assign md_operand_b_o = b_q;
   assign md_rd_addr_o   = rd_q;
   assign md_rd_we_o     = we_q && busy && !refresh_pip_i && !to;
   assign div_start_o    = ds;
   assign wb_valid_o     = wb;
   assign timeout_o      = to;
   assign refresh_pip_o  = (busy && refresh_pip_i) || to;
   assign stall_o        = busy && !(wb || refresh_pip_i || to);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: directed M-ops, expected
// completion/flush/timeout events queued and checked by a monitor.
module tb_md_issue_ctrl;
   import milano_pkg::*;

   localparam int K_WB = 0;
   localparam int K_FL = 1;
   localparam int K_TO = 2;

   typedef struct {
      int          kind;
      int          cyc;
      md_opt_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   md_opt_e     req_op_i;
   logic [31:0] req_a_i;
   logic [31:0] req_b_i;
   logic [4:0]  req_rd_addr_i;
   logic        req_rd_we_i;
   md_opt_e     md_operate_o;
   logic [31:0] md_operand_a_o;
   logic [31:0] md_operand_b_o;
   logic [4:0]  md_rd_addr_o;
   logic        md_rd_we_o;
   logic        div_start_o;
   logic        div_done_i;
   logic        div_busy_i;
   logic        refresh_pip_i;
   logic        refresh_pip_o;
   logic        stall_o;
   logic        wb_valid_o;
   logic        timeout_o;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   ds_cnt = 0;
   int   st_cnt = 0;
   exp_t q[$];
   exp_t e;
   int   k;

   md_issue_ctrl #(
      .MAX_DIV_CYCLES(40),
      .CNT_W(6)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_op_i(req_op_i),
      .req_a_i(req_a_i),
      .req_b_i(req_b_i),
      .req_rd_addr_i(req_rd_addr_i),
      .req_rd_we_i(req_rd_we_i),
      .md_operate_o(md_operate_o),
      .md_operand_a_o(md_operand_a_o),
      .md_operand_b_o(md_operand_b_o),
      .md_rd_addr_o(md_rd_addr_o),
      .md_rd_we_o(md_rd_we_o),
      .div_start_o(div_start_o),
      .div_done_i(div_done_i),
      .div_busy_i(div_busy_i),
      .refresh_pip_i(refresh_pip_i),
      .refresh_pip_o(refresh_pip_o),
      .stall_o(stall_o),
      .wb_valid_o(wb_valid_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (div_start_o) ds_cnt++;
         if (stall_o) st_cnt++;
      end
   end

   always @(negedge clk) begin
      if (!rst && (wb_valid_o || refresh_pip_o || timeout_o)) begin
         k = timeout_o ? K_TO : (wb_valid_o ? K_WB : K_FL);
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d required none",
                     k, cyc);
         end else begin
            e = q.pop_front();
            if (k != e.kind || cyc != e.cyc || md_operate_o != e.op ||
                md_operand_a_o != e.a || md_operand_b_o != e.b ||
                md_rd_addr_o != e.rd || md_rd_we_o != e.we ||
                (k == K_TO && !refresh_pip_o)) begin
               n_fail++;
               $display({"FAIL scoreboard actual kind=%0d cyc=%0d op=%0d ",
                         "a=%h b=%h rd=%0d we=%b rf=%b required kind=%0d ",
                         "cyc=%0d op=%0d a=%h b=%h rd=%0d we=%b"},
                        k, cyc, md_operate_o, md_operand_a_o,
                        md_operand_b_o, md_rd_addr_o, md_rd_we_o,
                        refresh_pip_o, e.kind, e.cyc, e.op, e.a, e.b,
                        e.rd, e.we);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic push(input int kind, input int c, input md_opt_e op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we);
      exp_t x;
      x.kind = kind;
      x.cyc  = c;
      x.op   = op;
      x.a    = a;
      x.b    = b;
      x.rd   = rd;
      x.we   = we;
      q.push_back(x);
   endtask

   task automatic issue(input md_opt_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic we, output int acc);
      req_valid_i   = 1'b1;
      req_op_i      = op;
      req_a_i       = a;
      req_b_i       = b;
      req_rd_addr_i = rd;
      req_rd_we_i   = we;
      @(negedge clk);
      chk("req_ready_at_issue", 32'(req_ready_o), 32'd1);
      acc = cyc;
      tick();
      req_valid_i   = 1'b0;
      req_op_i      = MD_OP_REMU;
      req_a_i       = 32'hDEAD_BEEF;
      req_b_i       = 32'hCAFE_F00D;
      req_rd_addr_i = 5'd31;
      req_rd_we_i   = ~we;
   endtask

   task automatic run(input int n, input int done_c, input int busy_till,
                      input int flush_c);
      for (int i = 0; i < n; i++) begin
         div_done_i    = (cyc == done_c);
         div_busy_i    = (cyc < busy_till);
         refresh_pip_i = (cyc == flush_c);
         @(negedge clk);
         tick();
      end
      div_done_i    = 1'b0;
      div_busy_i    = 1'b0;
      refresh_pip_i = 1'b0;
   endtask

   task automatic clr();
      ds_cnt = 0;
      st_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit expired");
      $fatal(1, "bench time limit");
   end

   initial begin
      int acc;
      int acc2;
      rst           = 1'b1;
      req_valid_i   = 1'b0;
      req_op_i      = MD_OP_MUL;
      req_a_i       = '0;
      req_b_i       = '0;
      req_rd_addr_i = '0;
      req_rd_we_i   = 1'b0;
      div_done_i    = 1'b0;
      div_busy_i    = 1'b0;
      refresh_pip_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_wb", 32'(wb_valid_o), 32'd0);
      chk("rst_start", 32'(div_start_o), 32'd0);
      chk("rst_refresh", 32'(refresh_pip_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_op", 32'(md_operate_o), 32'(MD_OP_MUL));
      chk("rst_a", md_operand_a_o, 32'd0);
      chk("rst_b", md_operand_b_o, 32'd0);
      chk("rst_rd", 32'(md_rd_addr_o), 32'd0);
      chk("rst_we", 32'(md_rd_we_o), 32'd0);
      rst = 1'b0;
      tick();

      // T1 multiply: completes one cycle after accept
      clr();
      issue(MD_OP_MUL, 32'd7, -32'sd3, 5'd5, 1'b1, acc);
      push(K_WB, acc + 1, MD_OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
      @(negedge clk);
      chk("t1_stall_t1", 32'(stall_o), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_ready_t2", 32'(req_ready_o), 32'd1);
      tick();

      // T2 DIVU with 34-cycle divider
      clr();
      issue(MD_OP_DIVU, 32'd100, 32'd7, 5'd6, 1'b1, acc);
      push(K_WB, acc + 35, MD_OP_DIVU, 32'd100, 32'd7, 5'd6, 1'b1);
      run(36, acc + 35, 0, -1);
      chk("t2_start_cycles", 32'(ds_cnt), 32'd1);
      chk("t2_stall_cycles", 32'(st_cnt), 32'd34);

      // T3 DIV with divider busy for three DIV_START cycles
      clr();
      issue(MD_OP_DIV, -32'sd20, 32'd3, 5'd7, 1'b1, acc);
      push(K_WB, acc + 10, MD_OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 1'b1);
      run(11, acc + 10, acc + 4, -1);
      chk("t3_start_cycles", 32'(ds_cnt), 32'd4);
      chk("t3_stall_cycles", 32'(st_cnt), 32'd9);

      // T4a REM flushed in DIV_WAIT cycle 5
      clr();
      issue(MD_OP_REM, -32'sd7, 32'd2, 5'd9, 1'b1, acc);
      push(K_FL, acc + 6, MD_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
      run(2, -1, 0, -1);
      run(6, acc + 7, 0, acc + 6);
      chk("t4a_stall_cycles", 32'(st_cnt), 32'd5);
      @(negedge clk);
      chk("t4a_ready_after", 32'(req_ready_o), 32'd1);
      tick();

      // T4b flush coincident with div_done
      clr();
      issue(MD_OP_REM, -32'sd7, 32'd2, 5'd10, 1'b1, acc);
      push(K_FL, acc + 4, MD_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
      run(6, acc + 4, 0, acc + 4);
      chk("t4b_stall_cycles", 32'(st_cnt), 32'd3);

      // flush while idle blocks acceptance
      req_valid_i   = 1'b1;
      req_op_i      = MD_OP_MUL;
      refresh_pip_i = 1'b1;
      @(negedge clk);
      chk("idle_flush_ready", 32'(req_ready_o), 32'd0);
      tick();
      req_valid_i   = 1'b0;
      refresh_pip_i = 1'b0;
      @(negedge clk);
      chk("idle_flush_noaccept", 32'(stall_o), 32'd0);
      tick();

      // T5 divider never finishes: watchdog
      clr();
      issue(MD_OP_DIVU, 32'd5, 32'd0, 5'd11, 1'b1, acc);
      push(K_TO, acc + 41, MD_OP_DIVU, 32'd5, 32'd0, 5'd11, 1'b0);
      run(43, -1, 0, -1);
      chk("t5_stall_cycles", 32'(st_cnt), 32'd40);
      chk("t5_start_cycles", 32'(ds_cnt), 32'd1);
      @(negedge clk);
      chk("t5_ready_after", 32'(req_ready_o), 32'd1);
      tick();

      // T6 asynchronous reset mid DIV_WAIT
      issue(MD_OP_DIV, 32'd50, 32'd5, 5'd12, 1'b1, acc);
      run(5, -1, 0, -1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_ready", 32'(req_ready_o), 32'd1);
      chk("t6_stall", 32'(stall_o), 32'd0);
      chk("t6_start", 32'(div_start_o), 32'd0);
      chk("t6_wb", 32'(wb_valid_o), 32'd0);
      chk("t6_refresh", 32'(refresh_pip_o), 32'd0);
      chk("t6_timeout", 32'(timeout_o), 32'd0);
      chk("t6_we", 32'(md_rd_we_o), 32'd0);
      chk("t6_a", md_operand_a_o, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      issue(MD_OP_MULH, 32'h8000_0000, 32'd2, 5'd13, 1'b1, acc);
      push(K_WB, acc + 1, MD_OP_MULH, 32'h8000_0000, 32'd2, 5'd13, 1'b1);
      run(1, -1, 0, -1);
      issue(MD_OP_DIVU, 32'd9, 32'd4, 5'd14, 1'b0, acc2);
      chk("t6_b2b_accept", 32'(acc2 - acc), 32'd2);
      push(K_WB, acc2 + 5, MD_OP_DIVU, 32'd9, 32'd4, 5'd14, 1'b0);
      run(7, acc2 + 5, 0, -1);
      run(3, -1, 0, -1);

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
